// File: rtl/snax_tcdm_responder_pkg.sv
// Shared configuration, address-decode helpers and default port struct types
// for the SNAX TCDM responder.
package snax_tcdm_responder_pkg;

    // Default configuration of the responder.
    localparam int DefaultNumPorts     = 16;
    localparam int DefaultNumBanks     = 32;
    localparam int DefaultWordsPerBank = 64;
    localparam int DefaultDataWidth    = 64;
    localparam int DefaultAddrWidth    = 17;

    // Field widths derived from the default configuration.
    localparam int ByteOffW = $clog2(DefaultDataWidth / 8);
    localparam int BankSelW = $clog2(DefaultNumBanks);
    localparam int RowW     = $clog2(DefaultWordsPerBank);

    typedef logic [BankSelW-1:0] bank_idx_t;

    typedef struct packed {
        logic [DefaultAddrWidth-1:0]   addr;
        logic                          write;
        logic [3:0]                    amo;
        logic [DefaultDataWidth-1:0]   data;
        logic [DefaultDataWidth/8-1:0] strb;
        logic [0:0]                    user;
    } snax_tcdm_req_chan_t;

    typedef struct packed {
        logic                q_valid;
        snax_tcdm_req_chan_t q;
    } snax_tcdm_req_t;

    typedef struct packed {
        logic [DefaultDataWidth-1:0] data;
    } snax_tcdm_rsp_chan_t;

    typedef struct packed {
        logic                q_ready;
        logic                p_valid;
        snax_tcdm_rsp_chan_t p;
    } snax_tcdm_rsp_t;

    // Bank index of a byte address: the low bits of the word address.
    function automatic int unsigned addr_to_bank(input logic [63:0] addr,
                                                 input int unsigned byte_off_w,
                                                 input int unsigned bank_sel_w);
        logic [63:0] word;
        word = addr >> byte_off_w;
        return 32'(word & ((64'd1 << bank_sel_w) - 64'd1));
    endfunction

    // Row inside the bank; addresses beyond capacity wrap through the mask.
    function automatic int unsigned addr_to_row(input logic [63:0] addr,
                                                input int unsigned byte_off_w,
                                                input int unsigned bank_sel_w,
                                                input int unsigned row_w);
        logic [63:0] word;
        word = addr >> (byte_off_w + bank_sel_w);
        return 32'(word & ((64'd1 << row_w) - 64'd1));
    endfunction

endpackage

// File: rtl/snax_tcdm_rr_arbiter.sv
// Round-robin arbiter for one bank: one-hot grant among requesting ports,
// search starts at rr_ptr, pointer moves past the winner on every grant.
module snax_tcdm_rr_arbiter
    import snax_tcdm_responder_pkg::*;
#(
    parameter int NumPorts = DefaultNumPorts
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumPorts-1:0] req,
    output logic [NumPorts-1:0] gnt
);

    localparam int PtrW = $clog2(NumPorts);

    logic [PtrW-1:0] rr_ptr_reg;
    logic [PtrW-1:0] rr_ptr_next;
    logic            found;

    // Pick the first requester at or after rr_ptr and advance the pointer past it.
    always_comb begin
        gnt         = '0;
        found       = 1'b0;
        rr_ptr_next = rr_ptr_reg;
        for (int i = 0; i < NumPorts; i++) begin
            if (!found && req[(int'(rr_ptr_reg) + i) % NumPorts]) begin
                found                                   = 1'b1;
                gnt[(int'(rr_ptr_reg) + i) % NumPorts]  = 1'b1;
                rr_ptr_next = PtrW'((int'(rr_ptr_reg) + i + 1) % NumPorts);
            end
        end
    end

    // Pointer register; holds when nothing is granted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

endmodule

// File: rtl/snax_tcdm_responder.sv
// Multi-port banked TCDM responder: word-interleaved SRAM model with per-bank
// round-robin arbitration, combinational q_ready and a one-cycle response.
module snax_tcdm_responder
    import snax_tcdm_responder_pkg::*;
#(
    parameter int  NumPorts     = DefaultNumPorts,
    parameter int  NumBanks     = DefaultNumBanks,
    parameter int  WordsPerBank = DefaultWordsPerBank,
    parameter int  DataWidth    = DefaultDataWidth,
    parameter int  AddrWidth    = DefaultAddrWidth,
    parameter type tcdm_req_t   = snax_tcdm_req_t,
    parameter type tcdm_rsp_t   = snax_tcdm_rsp_t
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  tcdm_req_t           tcdm_req_i [NumPorts],
    output tcdm_rsp_t           tcdm_rsp_o [NumPorts],
    input  logic [NumPorts-1:0] stall_i,
    output logic [31:0]         conflict_cnt_o
);

    localparam int StrbW = DataWidth / 8;
    localparam int OffW  = $clog2(StrbW);
    localparam int SelW  = $clog2(NumBanks);
    localparam int RwW   = $clog2(WordsPerBank);

    // Per-port decode and handshake
    logic [SelW-1:0]      port_bank [NumPorts];
    logic [RwW-1:0]       port_row  [NumPorts];
    logic [NumPorts-1:0]  eligible;
    logic [NumPorts-1:0]  granted;
    logic [NumPorts-1:0]  accept;
    logic [NumPorts-1:0]  lost;
    logic                 unused_fields;

    // Per-bank arbitration and write port
    logic [NumPorts-1:0]  bank_req   [NumBanks];
    logic [NumPorts-1:0]  bank_gnt   [NumBanks];
    logic                 bank_we    [NumBanks];
    logic [RwW-1:0]       bank_row   [NumBanks];
    logic [DataWidth-1:0] bank_wdata [NumBanks];
    logic [StrbW-1:0]     bank_strb  [NumBanks];

    // Storage and response pipeline
    logic [DataWidth-1:0] mem [NumBanks][WordsPerBank];
    logic [NumPorts-1:0]  p_valid_reg;
    logic [DataWidth-1:0] p_data_reg [NumPorts];
    logic [31:0]          conflict_cnt_reg;

    // Decode every port's address into bank/row; stalled ports never compete.
    always_comb begin
        unused_fields = 1'b0;
        for (int p = 0; p < NumPorts; p++) begin
            port_bank[p] = SelW'(addr_to_bank(64'(tcdm_req_i[p].q.addr), OffW, SelW));
            port_row[p]  = RwW'(addr_to_row(64'(tcdm_req_i[p].q.addr), OffW, SelW, RwW));
            eligible[p]  = tcdm_req_i[p].q_valid & ~stall_i[p];
            unused_fields = unused_fields ^ (^{tcdm_req_i[p].q.amo, tcdm_req_i[p].q.user});
        end
    end

    // Spread eligible requests into one request vector per bank.
    always_comb begin
        for (int b = 0; b < NumBanks; b++) begin
            for (int p = 0; p < NumPorts; p++) begin
                bank_req[b][p] = eligible[p] && (int'(port_bank[p]) == b);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NumBanks; gi++) begin : g_bank_arb
            snax_tcdm_rr_arbiter #(
                .NumPorts (NumPorts)
            ) u_arb (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .req    (bank_req[gi]),
                .gnt    (bank_gnt[gi])
            );
        end
    endgenerate

    // OR the per-bank grants into q_ready; nothing is granted while in reset.
    always_comb begin
        granted = '0;
        for (int b = 0; b < NumBanks; b++) begin
            granted = granted | bank_gnt[b];
        end
        accept = granted & {NumPorts{rst_ni}};
        lost   = eligible & ~granted;
    end

    // Steer the single winner of each bank onto that bank's write port.
    always_comb begin
        for (int b = 0; b < NumBanks; b++) begin
            bank_we[b]    = 1'b0;
            bank_row[b]   = '0;
            bank_wdata[b] = '0;
            bank_strb[b]  = '0;
            for (int p = 0; p < NumPorts; p++) begin
                if (bank_gnt[b][p] && accept[p]) begin
                    bank_we[b]    = tcdm_req_i[p].q.write;
                    bank_row[b]   = port_row[p];
                    bank_wdata[b] = tcdm_req_i[p].q.data;
                    bank_strb[b]  = tcdm_req_i[p].q.strb;
                end
            end
        end
    end

    // Byte-masked memory write; contents are deliberately kept across reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NumBanks; b++) begin
            if (bank_we[b]) begin
                for (int k = 0; k < StrbW; k++) begin
                    if (bank_strb[b][k]) begin
                        mem[b][bank_row[b]][8*k +: 8] <= bank_wdata[b][8*k +: 8];
                    end
                end
            end
        end
    end

    // Per-port response registers: pre-write read data for loads, zero for stores.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_valid_reg <= '0;
            for (int p = 0; p < NumPorts; p++) begin
                p_data_reg[p] <= '0;
            end
        end else begin
            p_valid_reg <= accept;
            for (int p = 0; p < NumPorts; p++) begin
                if (accept[p] && !tcdm_req_i[p].q.write) begin
                    p_data_reg[p] <= mem[port_bank[p]][port_row[p]];
                end else begin
                    p_data_reg[p] <= '0;
                end
            end
        end
    end

    // Saturating count of cycles in which some eligible request was not granted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_cnt_reg <= '0;
        end else if (|lost && (conflict_cnt_reg != 32'hFFFF_FFFF)) begin
            conflict_cnt_reg <= conflict_cnt_reg + 32'd1;
        end
    end

    assign conflict_cnt_o = conflict_cnt_reg;

    // Pack the response structs.
    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            tcdm_rsp_o[p]         = '0;
            tcdm_rsp_o[p].q_ready = accept[p];
            tcdm_rsp_o[p].p_valid = p_valid_reg[p];
            tcdm_rsp_o[p].p.data  = p_data_reg[p];
        end
    end

endmodule
